tcb_img_stream_packer: RTL and testbench

- Front end for the TCB classifier tops: accepts an AXI-Stream pixel stream, assembles one complete IMG_H x IMG_W image into the wide `img_source` vector, and hands it to the classifier over a valid/ready handshake.
- Two image slots (ping-pong), so the next frame fills while the classifier consumes the current one.
- Checks frame length against TLAST, drops malformed frames and resynchronises on the next TLAST; exposes frame and error counters.

---
 rtl/tcb_pkg.sv | 40 ++++
 rtl/tcb_img_slot.sv | 54 +++++
 rtl/tcb_img_stream_packer.sv | 198 +++++++++++++++++++
 tb/tb_tcb_img_stream_packer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcb_pkg.sv
// ----------------------------------------------------------------------------
// tcb_pkg
// Shared definitions for the TCB image stream packer:
//   - default image geometry and the derived constants NPIX / IMG_BITS / NBEATS
//   - constant functions to re-derive those for any parameterisation
//   - pix_msb(): bit position of pixel n inside the packed image vector
//   - wr_state_e: write-side FSM states
// ----------------------------------------------------------------------------
package tcb_pkg;

    localparam int IMG_W_DEF    = 11;
    localparam int IMG_H_DEF    = 11;
    localparam int PIX_W_DEF    = 8;
    localparam int BEAT_PIX_DEF = 4;

    localparam int NPIX     = IMG_W_DEF * IMG_H_DEF;
    localparam int IMG_BITS = NPIX * PIX_W_DEF;
    localparam int NBEATS   = (NPIX + BEAT_PIX_DEF - 1) / BEAT_PIX_DEF;

    // Number of input beats needed to carry npix pixels (ceiling division).
    function automatic int calc_nbeats(input int npix, input int beat_pix);
        return (npix + beat_pix - 1) / beat_pix;
    endfunction

    // Width of a beat index counter; never narrower than one bit.
    function automatic int calc_bidx_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

    // Pixel 0 sits in the most significant bits of the image vector.
    function automatic int pix_msb(input int n, input int img_bits, input int pix_w);
        return img_bits - 1 - n * pix_w;
    endfunction

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } wr_state_e;

endpackage

// File: rtl/tcb_img_slot.sv
// ----------------------------------------------------------------------------
// tcb_img_slot
// One complete image buffer. Each pixel register is written when the current
// beat index matches the beat that carries that pixel. Pixels of the final
// beat that lie beyond NPIX have no register, so they are simply ignored.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   we          write the pixels carried by the current beat
//   beat_idx    index of the beat being written
//   beat_data   BEAT_PIX pixels; pixel k in bits [k*PIX_W +: PIX_W]
//   img         packed image; pixel n in [IMG_BITS-1-n*PIX_W -: PIX_W]
// ----------------------------------------------------------------------------
module tcb_img_slot
    import tcb_pkg::*;
#(
    parameter int NPIX     = tcb_pkg::NPIX,
    parameter int PIX_W    = 8,
    parameter int BEAT_PIX = 4,
    parameter int BIDX_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [BIDX_W-1:0]         beat_idx,
    input  logic [BEAT_PIX*PIX_W-1:0] beat_data,
    output logic [NPIX*PIX_W-1:0]     img
);

    localparam int SLOT_BITS = NPIX * PIX_W;

    for (genvar n = 0; n < NPIX; n++) begin : g_pix
        localparam int                MSB   = pix_msb(n, SLOT_BITS, PIX_W);
        localparam int                LANE  = (n % BEAT_PIX) * PIX_W;
        localparam logic [BIDX_W-1:0] BEAT  = BIDX_W'(n / BEAT_PIX);

        logic [PIX_W-1:0] pix_q;

        // NOTE: the image store is an array of plain flops rather than a RAM,
        // so it is reset; that keeps img_source deterministic after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pix_q <= '0;
            end else if (we && (beat_idx == BEAT)) begin
                // NOTE: state is updated with non-blocking assignments so every
                // flop samples values from before the clock edge.
                pix_q <= beat_data[LANE +: PIX_W];
            end
        end

        assign img[MSB -: PIX_W] = pix_q;
    end

endmodule

// File: rtl/tcb_img_stream_packer.sv
// ----------------------------------------------------------------------------
// tcb_img_stream_packer
// Assembles an AXI-Stream pixel stream into complete IMG_H x IMG_W images and
// hands them to the classifier over a valid/ready handshake. Two image slots
// work ping-pong so one frame can fill while the other is being consumed.
// Frames whose length disagrees with TLAST are dropped; after a long frame
// the input is drained until the next TLAST.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   s_axis_tdata    pixel beat; pixel k in bits [k*PIX_W +: PIX_W]
//   s_axis_tvalid   beat valid
//   s_axis_tready   beat accepted when tvalid & tready
//   s_axis_tlast    last beat of a frame
//   img_source      assembled image from the read slot (0 when empty)
//   valid_top       an image is available
//   ready_top       classifier consumes the image on valid_top & ready_top
//   frame_cnt       images delivered, wraps
//   err_cnt         frames dropped, saturates
//   err_sticky      set on any framing error
//   clr_err         synchronous clear of err_cnt / err_sticky
// ----------------------------------------------------------------------------
module tcb_img_stream_packer
    import tcb_pkg::*;
#(
    parameter int IMG_W    = 11,
    parameter int IMG_H    = 11,
    parameter int PIX_W    = 8,
    parameter int BEAT_PIX = 4,
    parameter int CNT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BEAT_PIX*PIX_W-1:0]       s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [IMG_W*IMG_H*PIX_W-1:0]    img_source,
    output logic                            valid_top,
    input  logic                            ready_top,
    output logic [CNT_W-1:0]                frame_cnt,
    output logic [CNT_W-1:0]                err_cnt,
    output logic                            err_sticky,
    input  logic                            clr_err
);

    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_BITS  = N_PIX * PIX_W;
    localparam int N_BEATS = calc_nbeats(N_PIX, BEAT_PIX);
    localparam int BIDX_W  = calc_bidx_w(N_BEATS);

    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(N_BEATS - 1);

    wr_state_e         state, state_d;
    logic [BIDX_W-1:0] beat_idx, beat_idx_d;
    logic              rst_done;
    logic              wr_sel, rd_sel;
    logic [1:0]        occ;
    logic              tready_c;
    logic              fill_we;
    logic              frame_done;
    logic              frame_err;
    logic              consume;
    logic [N_BITS-1:0] slot_img [2];

    // tready is held low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            beat_idx <= '0;
        end else begin
            state    <= state_d;
            beat_idx <= beat_idx_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state;
        beat_idx_d = beat_idx;
        tready_c   = 1'b0;
        fill_we    = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;

        unique case (state)
            FILL: begin
                // Stalling only at beat 0 guarantees a started frame always
                // has a free slot to land in.
                tready_c = rst_done && ((occ != 2'd2) || (beat_idx != '0));
                if (s_axis_tvalid && tready_c) begin
                    fill_we = 1'b1;
                    if (beat_idx == LAST_BEAT) begin
                        beat_idx_d = '0;
                        if (s_axis_tlast) begin
                            frame_done = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        frame_err  = 1'b1;
                        beat_idx_d = '0;
                    end else begin
                        beat_idx_d = beat_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                tready_c = rst_done;
                if (s_axis_tvalid && tready_c && s_axis_tlast) begin
                    state_d    = FILL;
                    beat_idx_d = '0;
                end
            end
            default: begin
                state_d    = FILL;
                beat_idx_d = '0;
            end
        endcase
    end

    assign s_axis_tready = tready_c;

    // ------------------------------------------------------------------
    // Image slots
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_slot
        tcb_img_slot #(
            .NPIX     (N_PIX),
            .PIX_W    (PIX_W),
            .BEAT_PIX (BEAT_PIX),
            .BIDX_W   (BIDX_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (fill_we && (wr_sel == 1'(i))),
            .beat_idx  (beat_idx),
            .beat_data (s_axis_tdata),
            .img       (slot_img[i])
        );
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and frame counter
    // ------------------------------------------------------------------
    assign valid_top  = (occ != 2'd0);
    assign consume    = valid_top && ready_top;
    assign img_source = valid_top ? slot_img[rd_sel] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            occ       <= 2'd0;
            frame_cnt <= '0;
        end else begin
            if (frame_done) wr_sel <= ~wr_sel;
            if (consume) begin
                rd_sel    <= ~rd_sel;
                frame_cnt <= frame_cnt + 1'b1;
            end
            // Completion and consume in the same cycle cancel out.
            unique case ({frame_done, consume})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error reporting; a new error wins over a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (frame_err) begin
            err_sticky <= 1'b1;
            if (clr_err)             err_cnt <= CNT_W'(1);
            else if (err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
        end else if (clr_err) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tcb_img_stream_packer.sv
// ----------------------------------------------------------------------------
// tb_tcb_img_stream_packer
// Directed bench for tcb_img_stream_packer at default geometry
// (11x11 pixels, 8-bit, 4 pixels per beat -> 31 beats per frame).
// Frames use pixel value = (pixel index + seed) mod 256; padding lanes of the
// final beat carry 0xFF. Inputs change on the falling edge, outputs are
// sampled on the falling edge or 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_tcb_img_stream_packer;

    localparam int IMG_W    = 11;
    localparam int IMG_H    = 11;
    localparam int PIX_W    = 8;
    localparam int BEAT_PIX = 4;
    localparam int CNT_W    = 16;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int IMG_BITS = NPIX * PIX_W;
    localparam int TD_W     = BEAT_PIX * PIX_W;
    localparam int NBEATS   = 31;
    localparam int BUDGET   = 400;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [TD_W-1:0]     tdata = '0;
    logic                tvalid = 1'b0;
    logic                tready;
    logic                tlast = 1'b0;
    logic [IMG_BITS-1:0] img_source;
    logic                valid_top;
    logic                ready_top = 1'b0;
    logic [CNT_W-1:0]    frame_cnt;
    logic [CNT_W-1:0]    err_cnt;
    logic                err_sticky;
    logic                clr_err = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    tcb_img_stream_packer #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .PIX_W    (PIX_W),
        .BEAT_PIX (BEAT_PIX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .img_source    (img_source),
        .valid_top     (valid_top),
        .ready_top     (ready_top),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .err_sticky    (err_sticky),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [IMG_BITS-1:0] got,
                         input logic [IMG_BITS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IMG_BITS-1:0] exp_img(input int seed);
        logic [IMG_BITS-1:0] r = '0;
        for (int n = 0; n < NPIX; n++)
            r[IMG_BITS-1-n*PIX_W -: PIX_W] = 8'(n + seed);
        return r;
    endfunction

    function automatic logic [TD_W-1:0] beat_of(input int seed, input int b);
        logic [TD_W-1:0] d = '0;
        for (int k = 0; k < BEAT_PIX; k++) begin
            int idx = b * BEAT_PIX + k;
            d[k*PIX_W +: PIX_W] = (idx < NPIX) ? 8'(idx + seed) : 8'hFF;
        end
        return d;
    endfunction

    // Input stability while stalled (interface assumption on the source).
    logic [TD_W-1:0] held_d = '0;
    logic            held_l = 1'b0;
    bit              hold_pend = 1'b0;
    always @(posedge clk) begin
        if (hold_pend && tvalid) begin
            check("hold_tdata", tdata, held_d);
            check("hold_tlast", tlast, held_l);
        end
        hold_pend = tvalid && !tready && rst_n;
        held_d    = tdata;
        held_l    = tlast;
    end

    // Present one beat; returns 1 time unit after the edge that accepted it.
    task automatic send_beat(input logic [TD_W-1:0] d, input logic l, input bit rt);
        int n = 0;
        @(negedge clk);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        if (rt) ready_top = 1'b1;
        while (!tready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!tready) check("tready_timeout", tready, 1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (rt) ready_top = 1'b0;
    endtask

    // nb beats, tlast on beat last_at (-1: never); rt_last raises ready_top
    // during the final beat only.
    task automatic send_frame(input int seed, input int nb, input int last_at,
                              input bit rt_last);
        for (int b = 0; b < nb; b++)
            send_beat(beat_of(seed, b), (b == last_at), rt_last && (b == nb - 1));
    endtask

    // Wait for an image, compare it, then consume it with a one-cycle ready.
    task automatic take(input int seed, input string tag);
        int n = 0;
        @(negedge clk);
        while (!valid_top && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, valid_top, 1);
        check({tag, "_img"}, img_source, exp_img(seed));
        ready_top = 1'b1;
        @(posedge clk);
        #1;
        ready_top = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        tdata     = '0;
        ready_top = 1'b0;
        clr_err   = 1'b0;
        #1;
        check("rst_tready", tready, 0);
        check("rst_valid", valid_top, 0);
        check("rst_img", img_source, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sticky", err_sticky, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tready", tready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- single frame, ready_top held high -------------
        do_reset();
        ready_top = 1'b1;
        send_frame(0, NBEATS, NBEATS - 1, 1'b0);
        check("s1_valid", valid_top, 1);
        check("s1_pix0", img_source[967:960], 8'h00);
        check("s1_pix120", img_source[7:0], 8'h78);
        check("s1_img", img_source, exp_img(0));
        @(posedge clk);
        #1;
        check("s1_valid_drop", valid_top, 0);
        check("s1_frame_cnt", frame_cnt, 1);
        ready_top = 1'b0;

        // ---------------- back-pressure: three frames -------------------
        do_reset();
        send_frame(10, NBEATS, NBEATS - 1, 1'b0);
        send_frame(20, NBEATS, NBEATS - 1, 1'b0);
        @(negedge clk);
        tdata  = beat_of(30, 0);
        tlast  = 1'b0;
        tvalid = 1'b1;
        #1;
        check("bp_tready_full", tready, 0);
        check("bp_hold_img", img_source, exp_img(10));
        fork
            send_frame(30, NBEATS, NBEATS - 1, 1'b0);
            begin
                take(10, "bp1");
                take(20, "bp2");
                take(30, "bp3");
            end
        join
        check("bp_frame_cnt", frame_cnt, 3);
        check("bp_empty", valid_top, 0);

        // ---------------- short frame -----------------------------------
        do_reset();
        send_frame(40, 11, 10, 1'b0);
        check("sh_valid", valid_top, 0);
        check("sh_err_cnt", err_cnt, 1);
        check("sh_sticky", err_sticky, 1);
        send_frame(50, NBEATS, NBEATS - 1, 1'b0);
        take(50, "sh_next");
        check("sh_frame_cnt", frame_cnt, 1);

        // ---------------- long frame, drain, clear ----------------------
        do_reset();
        send_frame(60, NBEATS + 5, NBEATS + 4, 1'b0);
        check("lg_valid", valid_top, 0);
        check("lg_err_cnt", err_cnt, 1);
        check("lg_sticky", err_sticky, 1);
        send_frame(70, NBEATS, NBEATS - 1, 1'b0);
        take(70, "lg_next");
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_err_cnt", err_cnt, 0);
        check("clr_sticky", err_sticky, 0);
        // Clear held across a short frame: the error on its last beat wins.
        clr_err = 1'b1;
        send_frame(80, 2, 1, 1'b0);
        clr_err = 1'b0;
        check("clrpri_err_cnt", err_cnt, 1);
        check("clrpri_sticky", err_sticky, 1);

        // ---------------- simultaneous completion and consume -----------
        do_reset();
        send_frame(90, NBEATS, NBEATS - 1, 1'b0);
        send_frame(100, NBEATS, NBEATS - 1, 1'b1);
        check("sim_valid", valid_top, 1);
        check("sim_frame_cnt1", frame_cnt, 1);
        check("sim_img2", img_source, exp_img(100));
        take(100, "sim2");
        check("sim_frame_cnt2", frame_cnt, 2);
        check("sim_empty", valid_top, 0);

        // ---------------- reset mid-frame -------------------------------
        do_reset();
        send_frame(110, NBEATS, NBEATS - 1, 1'b0);
        send_frame(120, 15, -1, 1'b0);
        check("mr_valid_before", valid_top, 1);
        do_reset();
        send_frame(130, NBEATS, NBEATS - 1, 1'b0);
        check("mr_frame_cnt0", frame_cnt, 0);
        take(130, "mr_after");
        check("mr_frame_cnt1", frame_cnt, 1);
        check("mr_empty", valid_top, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
